pwm_multi_gen: RTL
==================

PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of motor channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 7, period counter width; period = 2^CNT_W cycles.
REQ-003 SHALL have parameter RAMP_STEP, default 16, max active-duty change per period (1..2^CNT_W-1).
REQ-004 CLK  in  1  single clock; all logic on posedge CLK.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 duty_cmd  in  N_CH*CNT_W  target duty per channel; ch i at bits [i*CNT_W +: CNT_W].
REQ-007 dir_cmd  in  N_CH  direction per channel; 0 = forward, 1 = reverse.
REQ-008 en  in  N_CH  channel enable; low forces target duty 0.
REQ-009 estop  in  1  emergency stop, all channels.
REQ-010 motor_fwd  out  N_CH  forward PWM, registered.
REQ-011 motor_rev  out  N_CH  reverse PWM, registered.
REQ-012 period_start  out  1  one-cycle pulse on first cycle of each period.
REQ-013 at_target  out  N_CH  high when active duty = effective target and direction matches.

Function
REQ-014 Shared counter SHALL run 0..2^CNT_W-1, wrap to 0; period_start high exactly when count = 0.
REQ-015 duty_cmd/dir_cmd/en SHALL be sampled only on the last cycle of a period (count = 2^CNT_W-1); mid-period changes have no effect until then.
REQ-016 Effective target = en[i] ? duty_cmd[i] : 0.
REQ-017 Active duty SHALL update once per sample: move toward target by RAMP_STEP; snap to target if |difference| <= RAMP_STEP; no overflow/underflow.
REQ-018 Per channel FSM SHALL have states IDLE, RUN, DECEL.
REQ-019 IDLE: active duty 0; to RUN at sample with target > 0 (latch dir_cmd as active dir).
REQ-020 RUN: ramp per REQ-017; to DECEL at sample where dir_cmd != active dir; to IDLE when active duty reaches 0 with target 0.
REQ-021 DECEL: ramp toward 0 regardless of target; on reaching 0 SHALL go IDLE, giving at least one full period at duty 0 before reversal.
REQ-022 During a period, active channel output (fwd if dir 0, rev if dir 1) SHALL be high for exactly active-duty cycles starting at the period_start cycle; inactive output low.
REQ-023 motor_fwd[i] and motor_rev[i] SHALL never be high in the same cycle.
REQ-024 Duty 0 -> output low whole period; duty 2^CNT_W-1 -> high all but the last cycle.
REQ-025 estop high SHALL drive all motor outputs low from the next cycle, force active duty 0, state IDLE; counter keeps running; after release, channels restart from 0 by normal ramp.
REQ-026 estop and RST simultaneous: RST governs.

Reset
REQ-027 RST SHALL set counter 0, all active duty 0, all FSMs IDLE, motor_fwd/rev 0, period_start 0, at_target 0, from the next edge.
REQ-028 First cycle after RST deasserts SHALL be count 0 with period_start high; RST mid-period SHALL abort the period with no partial pulse.

Structure
REQ-029 Package pwm_pkg SHALL hold the FSM state enum and default values for N_CH, CNT_W, RAMP_STEP.
REQ-030 Per-channel FSM, ramp, and compare SHALL be in sub-module pwm_channel, instantiated N_CH times via generate; counter stays in top.

Verification (N_CH=2, CNT_W=7, RAMP_STEP=16)
REQ-031 Reset, ch0 duty 64 fwd en=1 -> fwd high 16/32/48/64 cycles in four successive periods; at_target[0] high from the 4th; rev[0] low.
REQ-032 ch0 at 64 fwd, dir_cmd->1 -> fwd 48/32/16/0, then rev 16/32/48/64; fwd and rev never overlap.
REQ-033 ch1 duty 0 -> outputs low all period; duty 127 after ramp -> high 127 of 128 cycles.
REQ-034 duty_cmd 32->96 at count 40 -> current period unchanged; next period 48.
REQ-035 estop at count 10 with ch0 at 64 -> fwd low from count 11; after release, ramp 16,32,...
REQ-036 RST at count 50 with both channels running -> all outputs low next cycle; count 0 and period_start on first post-reset cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and parameter defaults for the multi-channel PWM generator.
package pwm_pkg;

  localparam int N_CH_DEF      = 2;
  localparam int CNT_W_DEF     = 7;
  localparam int RAMP_STEP_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2
  } chState_e;

endpackage

// File: rtl/pwm_channel.sv
// One motor channel: direction FSM, per-period duty ramp and PWM compare
// against the next value of the shared period counter.
module pwm_channel import pwm_pkg::*; #(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             estop_i,
  input  logic             sample_i,
  input  logic [CNT_W-1:0] cntNext_i,
  input  logic [CNT_W-1:0] dutyCmd_i,
  input  logic             dirCmd_i,
  input  logic             en_i,
  output logic             fwd_o,
  output logic             rev_o,
  output logic             atTarget_o
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

  chState_e         state_q, state_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] target, goal, ramped;
  logic             dir_q, dir_d;
  logic             atTarget_q, atTarget_d;
  logic             fwd_q, rev_q;
  logic             reversing;

  // A direction change never reverses directly: the channel first ramps to 0
  // and parks in IDLE for a period, where it picks up the new direction.
  always_comb begin
    target    = en_i ? dutyCmd_i : '0;
    reversing = (state_q == ST_RUN) && (dirCmd_i != dir_q);
    goal      = (reversing || (state_q == ST_DECEL)) ? '0 : target;

    ramped = goal;
    if ((goal > duty_q) && ((goal - duty_q) > STEP)) begin
      ramped = duty_q + STEP;
    end else if ((goal < duty_q) && ((duty_q - goal) > STEP)) begin
      ramped = duty_q - STEP;
    end

    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    atTarget_d = atTarget_q;
    if (sample_i) begin
      duty_d = ramped;
      dir_d  = (state_q == ST_IDLE) ? dirCmd_i : dir_q;
      case (state_q)
        ST_IDLE:  state_d = (ramped != '0) ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (ramped == '0) begin
            state_d = ST_IDLE;
          end else if (reversing) begin
            state_d = ST_DECEL;
          end
        end
        ST_DECEL: state_d = (ramped == '0) ? ST_IDLE : ST_DECEL;
        default:  state_d = ST_IDLE;
      endcase
      atTarget_d = (ramped == target) && (dir_d == dirCmd_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || estop_i) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      atTarget_q <= 1'b0;
      fwd_q      <= 1'b0;
      rev_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      atTarget_q <= atTarget_d;
      fwd_q      <= !dir_d && (cntNext_i < duty_d);
      rev_q      <= dir_d && (cntNext_i < duty_d);
    end
  end

  assign fwd_o      = fwd_q;
  assign rev_o      = rev_q;
  assign atTarget_o = atTarget_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel H-bridge PWM generator: one shared period counter driving
// N_CH independently ramped direction-aware channels.
module pwm_multi_gen import pwm_pkg::*; #(
  parameter int N_CH      = N_CH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH*CNT_W-1:0] duty_cmd,
  input  logic [N_CH-1:0]       dir_cmd,
  input  logic [N_CH-1:0]       en,
  input  logic                  estop,
  output logic [N_CH-1:0]       motor_fwd,
  output logic [N_CH-1:0]       motor_rev,
  output logic                  period_start,
  output logic [N_CH-1:0]       at_target
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q;
  logic             periodStart_q;
  logic             sample;

  // The first cycle after reset keeps the count at 0 so it opens a full period.
  always_comb begin
    cnt_d  = running_q ? cnt_q + CNT_W'(1) : '0;
    sample = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q         <= '0;
      running_q     <= 1'b0;
      periodStart_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      running_q     <= 1'b1;
      periodStart_q <= (cnt_d == '0);
    end
  end

  assign period_start = periodStart_q;

  for (genvar i = 0; i < N_CH; i++) begin : gChannel
    pwm_channel #(
      .CNT_W     (CNT_W),
      .RAMP_STEP (RAMP_STEP)
    ) uChannel (
      .clk_i      (CLK),
      .rst_i      (RST),
      .estop_i    (estop),
      .sample_i   (sample),
      .cntNext_i  (cnt_d),
      .dutyCmd_i  (duty_cmd[i*CNT_W +: CNT_W]),
      .dirCmd_i   (dir_cmd[i]),
      .en_i       (en[i]),
      .fwd_o      (motor_fwd[i]),
      .rev_o      (motor_rev[i]),
      .atTarget_o (at_target[i])
    );
  end

endmodule
